uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
Oversampled UART transmitter. Serialises one DATA_BITS word per frame onto tx_pin: start bit, data LSB-first, optional odd parity bit, one stop bit. Shares the tick_16x baud strobe and frame format with the team's uart_rx so the two loop back directly. A one-entry holding register lets the next word be accepted while the current frame shifts out, so frames go back-to-back with no idle gap.

Parameters:
- DATA_BITS, 8, data bits per frame.
- OVS_FACTOR, 16, tick_16x strobes per bit period.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- tick_16x  in  1  one-clk baud oversample strobe.
- tx_data  in  DATA_BITS  word to send.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  holding register empty; accept when tx_valid && tx_ready.
- parity_enable  in  1  adds an odd parity bit to the frame; sampled at accept.
- tx_pin  out  1  serial line, idle high.
- tx_busy  out  1  frame in progress (state != IDLE).
- tx_done  out  1  one-clk pulse at end of each stop bit.

Behaviour:
- Reset (async assert, sync release):
  - tx_pin=1, tx_ready=1, tx_busy=0, tx_done=0.
  - Holding register empty; state IDLE; os_count=0; bit_index=0.
  - Reset mid-frame aborts the frame and returns the line high immediately.
- Accept:
  - On a clk edge with tx_valid && tx_ready, latch tx_data and parity_enable into the holding register.
  - tx_ready drops on the next cycle. tx_ready is a registered function of holding-empty.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx_pin=1.
  - If holding is full: move it into the shift register, compute par = ~^data, mark holding empty, os_count=0, go to START.
  - tx_pin=0 on the following cycle, so tx_pin falls 2 clks after accept.
  - tx_ready rises in the same cycle START is entered.
- Bit timing:
  - os_count increments only on tick_16x.
  - A bit ends on a tick with os_count==OVS_FACTOR-1. On that tick os_count resets to 0 and the FSM advances.
  - Each bit therefore lasts exactly OVS_FACTOR ticks.
  - os_count width is $clog2(OVS_FACTOR), with a minimum of 1.
- START: tx_pin=0. After OVS_FACTOR ticks go to DATA with bit_index=0.
- DATA:
  - tx_pin = shift[bit_index].
  - At bit end: if bit_index==DATA_BITS-1, go to PARITY when the latched parity_enable is 1, else STOP. Otherwise increment bit_index.
- PARITY: tx_pin = par, so the count of ones over data+parity is odd. After one bit period go to STOP.
- STOP:
  - tx_pin=1.
  - At bit end, pulse tx_done for one clk.
  - If holding is full, load it and go directly to START (tx_pin=0 next cycle, no idle bit). Otherwise go to IDLE.
- tx_pin is driven from a register (glitch-free); no combinational path from inputs.
- Changes to tx_data and parity_enable after accept have no effect on the frame in flight.
- tick_16x held low stalls the frame indefinitely with tx_pin steady. This is legal.
- Simultaneous accept and holding unload cannot occur: tx_ready is low while holding is full, and the new accept lands one cycle after the unload.
- An illegal state decode returns to IDLE with tx_pin=1.

Decomposition:
- Shared package uart_pkg:
  - FSM state typedef for tx; rx reuses the same package for its own enum.
  - Defaults for DATA_BITS and OVS_FACTOR.
  - An odd-parity helper function used by both tx (generate) and rx (check).
- No sub-module; the baud tick comes from the existing baud generator.
- The holding register plus handshake could be split into uart_tx_hold, but stays inline at this size.

Test Plan:
(All scenarios use OVS_FACTOR=16 and tick_16x=1 every clk unless stated.)
1. Single frame: send 0xA5, parity off → tx_pin: 16 clks 0; then 1,0,1,0,0,1,0,1 at 16 clks each; 16 clks 1. tx_done pulses once, 160 clks after tx_pin falls. tx_busy is high throughout.
2. Odd parity: send 0xA5 → parity bit 1. Send 0x01 → 0. Send 0x00 → 1. Each frame is 176 clks.
3. Back-to-back with 0x3C then 0xC3, both offered immediately:
   - Second accept occurs while the first is in START.
   - The stop bit of frame 1 is followed directly by the start bit of frame 2; no extra high clks.
   - tx_ready is low only between the two loads.
4. Tick gating: tick_16x every 4th clk → each bit is 64 clks. Holding tick_16x low for 100 clks mid-DATA freezes tx_pin.
5. Reset mid-frame: assert reset_n=0 during DATA bit 3 → tx_pin=1 and tx_ready=1 asynchronously. After release, a new 0x5A frame is correct.
6. Loopback into uart_rx, random 500 words with random parity_enable and random tick spacing → rx_data matches every word; parity_err=0 and frame_err=0 throughout.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART frame defaults, tx FSM states and odd-parity helper
package uart_pkg;
  localparam int DEFAULT_DATA_BITS = 8;
  localparam int DEFAULT_OVS_FACTOR = 16;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  // Odd parity bit over a zero-extended word; extra zeros do not change the result
  function automatic logic odd_parity(input logic [63:0] d);
    return ~^d;
  endfunction
endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: valid/ready word handshake into the UART transmitter
interface uart_tx_if #(parameter int DATA_BITS = uart_pkg::DEFAULT_DATA_BITS);
  logic [DATA_BITS-1:0] tx_data;
  logic tx_valid;
  logic tx_ready;
  logic parity_enable;
  modport master (output tx_data, tx_valid, parity_enable, input tx_ready);
  modport slave (input tx_data, tx_valid, parity_enable, output tx_ready);
endinterface

// File: rtl/uart_tx.sv
// uart_tx: oversampled UART transmitter with a one-entry holding register
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DEFAULT_DATA_BITS,
  parameter int OVS_FACTOR = DEFAULT_OVS_FACTOR
) (
  input logic clk,
  input logic reset_n,
  input logic tick_16x,
  uart_tx_if.slave s,
  output logic tx_pin,
  output logic tx_busy,
  output logic tx_done
);
  localparam int OW = OVS_FACTOR > 1 ? $clog2(OVS_FACTOR) : 1;
  localparam int BW = DATA_BITS > 1 ? $clog2(DATA_BITS) : 1;
  tx_state_t state;
  logic [OW-1:0] os_count;
  logic [BW-1:0] bit_index;
  logic [DATA_BITS-1:0] hold_data, shift;
  logic hold_full, hold_pe, pe, par, ready_q;
  logic accept, bit_end, last_bit, load;
  assign s.tx_ready = ready_q;
  // Handshake, end-of-bit and holding-unload decode
  always_comb begin
    accept = s.tx_valid && ready_q;
    bit_end = tick_16x && os_count == OW'(OVS_FACTOR - 1);
    last_bit = bit_index == BW'(DATA_BITS - 1);
    load = hold_full && (state == TX_IDLE || (state == TX_STOP && bit_end));
  end
  // Holding register plus frame FSM; tx_pin is registered with the value of the state being entered
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= TX_IDLE;
      os_count <= '0;
      bit_index <= '0;
      hold_full <= 1'b0;
      hold_data <= '0;
      hold_pe <= 1'b0;
      shift <= '0;
      pe <= 1'b0;
      par <= 1'b0;
      ready_q <= 1'b1;
      tx_pin <= 1'b1;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (accept) begin
        hold_full <= 1'b1;
        hold_data <= s.tx_data;
        hold_pe <= s.parity_enable;
        ready_q <= 1'b0;
      end else if (load) begin
        hold_full <= 1'b0;
        ready_q <= 1'b1;
      end
      if (load) begin
        shift <= hold_data;
        pe <= hold_pe;
        par <= odd_parity(64'(hold_data));
      end
      if (tick_16x && state != TX_IDLE) os_count <= bit_end ? '0 : os_count + 1'b1;
      case (state)
        TX_IDLE: begin
          state <= load ? TX_START : TX_IDLE;
          tx_pin <= !load;
          tx_busy <= load;
          os_count <= '0;
          bit_index <= '0;
        end
        TX_START: if (bit_end) begin
          state <= TX_DATA;
          bit_index <= '0;
          tx_pin <= shift[0];
        end
        TX_DATA: if (bit_end) begin
          state <= !last_bit ? TX_DATA : pe ? TX_PARITY : TX_STOP;
          bit_index <= last_bit ? bit_index : bit_index + 1'b1;
          tx_pin <= !last_bit ? shift[bit_index + 1'b1] : pe ? par : 1'b1;
        end
        TX_PARITY: if (bit_end) begin
          state <= TX_STOP;
          tx_pin <= 1'b1;
        end
        TX_STOP: if (bit_end) begin
          state <= load ? TX_START : TX_IDLE;
          tx_pin <= !load;
          tx_busy <= load;
          tx_done <= 1'b1;
        end
        default: begin
          state <= TX_IDLE;
          tx_pin <= 1'b1;
          tx_busy <= 1'b0;
          os_count <= '0;
          bit_index <= '0;
        end
      endcase
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: frame-level model check of uart_tx plus literal waveform expectations
module tb_uart_tx;
  localparam int DB = 8;
  localparam int OVS = 16;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic tick_16x = 1'b0;
  logic tx_pin, tx_busy, tx_done;
  int n_chk = 0;
  int n_fail = 0;
  int tick_div = 1;
  int tick_ph = 0;
  bit tick_hold = 0;
  bit tick_rand = 0;
  uart_tx_if #(.DATA_BITS(DB)) bus ();
  uart_tx #(.DATA_BITS(DB), .OVS_FACTOR(OVS)) dut (
    .clk(clk), .reset_n(reset_n), .tick_16x(tick_16x), .s(bus.slave),
    .tx_pin(tx_pin), .tx_busy(tx_busy), .tx_done(tx_done));
  always #5 clk = ~clk;
  // Baud strobe generator: every clk, every Nth clk, random, or held low
  always @(posedge clk) begin
    #1;
    tick_ph = (tick_ph + 1) % tick_div;
    tick_16x = !tick_hold && (tick_rand ? ($urandom_range(0, 2) == 0) : (tick_ph == 0));
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // Model: a frame is a list of line levels, each held for OVS ticks; one word may wait behind it
  bit bits[$];
  bit m_full = 0, m_pe = 0, m_busy = 0, m_acc = 0, m_ld = 0;
  logic [DB-1:0] m_data = '0;
  int m_cnt = 0;
  logic exp_pin = 1'b1, exp_ready = 1'b1, exp_busy = 1'b0, exp_done = 1'b0;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_full = 0; m_busy = 0; m_cnt = 0; bits.delete(); exp_done = 1'b0;
    end else begin
      m_acc = bus.tx_valid && !m_full;
      m_ld = 0;
      exp_done = 1'b0;
      if (m_busy) begin
        if (tick_16x) m_cnt++;
        if (m_cnt == OVS) begin
          m_cnt = 0;
          void'(bits.pop_front());
          if (bits.size() == 0) begin
            exp_done = 1'b1;
            m_busy = 0;
            m_ld = m_full;
          end
        end
      end else m_ld = m_full;
      if (m_ld) begin
        bits.delete();
        bits.push_back(1'b0);
        for (int i = 0; i < DB; i++) bits.push_back(m_data[i]);
        if (m_pe) bits.push_back($countones(m_data) % 2 == 0);
        bits.push_back(1'b1);
        m_busy = 1; m_full = 0; m_cnt = 0;
      end
      if (m_acc) begin
        m_full = 1; m_data = bus.tx_data; m_pe = bus.parity_enable;
      end
    end
    exp_pin = m_busy ? bits[0] : 1'b1;
    exp_ready = !m_full;
    exp_busy = m_busy;
  end
  // Every-cycle comparison against the model
  always @(negedge clk) begin
    chk("pin", tx_pin, exp_pin);
    chk("ready", bus.tx_ready, exp_ready);
    chk("busy", tx_busy, exp_busy);
    chk("done", tx_done, exp_done);
  end
  task automatic send(input logic [DB-1:0] d, input bit pe);
    @(posedge clk); #1;
    bus.tx_data = d; bus.parity_enable = pe; bus.tx_valid = 1'b1;
    for (int k = 0; ; k++) begin
      @(negedge clk);
      if (bus.tx_ready === 1'b1) break;
      if (k > 5000) begin chk("send_timeout", 0, 1); break; end
    end
    @(posedge clk); #1;
    bus.tx_valid = 1'b0; bus.tx_data = DB'($urandom); bus.parity_enable = 1'($urandom);
  endtask
  // Observe one frame: clks to fall, line sampled mid-bit, clks from fall to done
  task automatic watch(input int bp, input int nb, output int fall, output logic [15:0] smp, output int dlen);
    fall = -1; dlen = -1; smp = '0;
    for (int k = 1; k <= 20 && fall < 0; k++) begin
      @(negedge clk);
      if (tx_pin === 1'b0) fall = k;
    end
    if (fall < 0) return;
    for (int t = 1; t <= 4000 && dlen < 0; t++) begin
      @(negedge clk);
      if (t % bp == bp / 2 && t / bp < nb) smp[t / bp] = tx_pin;
      if (tx_done === 1'b1) dlen = t;
    end
  endtask
  task automatic wait_idle(input int bound);
    for (int k = 0; k <= bound; k++) begin
      @(negedge clk);
      if (tx_busy === 1'b0 && bus.tx_ready === 1'b1) return;
    end
    chk("idle_timeout", 0, 1);
  endtask
  int fall, dlen, cnt;
  logic [15:0] smp;
  logic [DB-1:0] pw [3] = '{8'hA5, 8'h01, 8'h00};
  bit pb [3] = '{1'b1, 1'b0, 1'b1};
  initial begin
    bus.tx_valid = 1'b0; bus.tx_data = '0; bus.parity_enable = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_pin", tx_pin, 1); chk("rst_ready", bus.tx_ready, 1);
    chk("rst_busy", tx_busy, 0); chk("rst_done", tx_done, 0);
    #2 reset_n = 1'b1;
    send(8'hA5, 0);
    watch(OVS, 10, fall, smp, dlen);
    chk("a5_fall", fall, 2); chk("a5_bits", smp[9:0], 10'b11010_01010); chk("a5_len", dlen, 160);
    for (int i = 0; i < 3; i++) begin
      send(pw[i], 1);
      watch(OVS, 11, fall, smp, dlen);
      chk("par_bit", smp[9], pb[i]); chk("par_stop", smp[10], 1); chk("par_len", dlen, 176);
    end
    send(8'h3C, 0);
    send(8'hC3, 0);
    chk("b2b_in_start", tx_pin, 0); chk("b2b_ready", bus.tx_ready, 0);
    cnt = -1;
    for (int t = 1; t <= 400 && cnt < 0; t++) begin
      @(negedge clk);
      if (tx_done === 1'b1) cnt = t;
    end
    chk("b2b_len", cnt, 160); chk("b2b_next_start", tx_pin, 0); chk("b2b_busy", tx_busy, 1);
    wait_idle(400);
    tick_div = 4;
    send(8'h96, 0);
    watch(4 * OVS, 10, fall, smp, dlen);
    chk("div4_bits", smp[9:0], 10'b11001_01100);
    chk("div4_len", (dlen >= 637 && dlen <= 640), 1);
    tick_div = 1;
    send(8'h0F, 0);
    repeat (16 * 3 + 5) @(negedge clk);
    tick_hold = 1;
    repeat (100) @(negedge clk);
    tick_hold = 0;
    wait_idle(400);
    send(8'h00, 0);
    repeat (74) @(negedge clk);
    chk("pre_rst_pin", tx_pin, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("async_pin", tx_pin, 1); chk("async_ready", bus.tx_ready, 1); chk("async_busy", tx_busy, 0);
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b1;
    send(8'h5A, 0);
    watch(OVS, 10, fall, smp, dlen);
    chk("5a_fall", fall, 2); chk("5a_bits", smp[9:0], 10'b10101_10100); chk("5a_len", dlen, 160);
    tick_rand = 1;
    for (int i = 0; i < 60; i++) send(DB'($urandom), 1'($urandom));
    wait_idle(5000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
